julia_iter: RTL and testbench

Per-pixel Julia/Mandelbrot iteration engine: accepts a starting point z0 and constant c in signed fixed point, iterates z ← z² + c one step per clock, and reports the escape iteration count as an 8-bit value. It sits directly upstream of the colour-mapping stage, which expects counts 0..MAX_ITER-1 for escaped points and 255 for points that never escaped. A pass-through tag, typically the framebuffer pixel address, travels with each job.

---
 rtl/julia_pkg.sv | 16 +
 rtl/julia_if.sv | 27 ++
 rtl/julia_step.sv | 31 +++
 rtl/julia_iter.sv | 83 ++++++++
 tb/tb_julia_iter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/julia_pkg.sv
// Shared constants and types for the Julia/Mandelbrot escape-count engine.
package julia_pkg;

   localparam int W_DEF    = 16;
   localparam int FRAC_DEF = 12;

   localparam logic [2*W_DEF:0] ESCAPE_THRESH = (2*W_DEF+1)'(4) << (2*FRAC_DEF);
   localparam logic [7:0]       COUNT_INSIDE  = 8'd255;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

endpackage

// File: rtl/julia_if.sv
// Job/result handshake bundle between the pixel scheduler and the iteration engine.
interface julia_if #(
   parameter int W     = 16,
   parameter int TAG_W = 17
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [W-1:0]     in_zr;
   logic signed [W-1:0]     in_zi;
   logic signed [W-1:0]     in_cr;
   logic signed [W-1:0]     in_ci;
   logic [TAG_W-1:0]        in_tag;
   logic                    out_valid;
   logic                    out_ready;
   logic [7:0]              out_count;
   logic [TAG_W-1:0]        out_tag;

   modport master (
      output in_valid, in_zr, in_zi, in_cr, in_ci, in_tag, out_ready,
      input  in_ready, out_valid, out_count, out_tag
   );

   modport slave (
      input  in_valid, in_zr, in_zi, in_cr, in_ci, in_tag, out_ready,
      output in_ready, out_valid, out_count, out_tag
   );
endinterface

// File: rtl/julia_step.sv
// One combinational z <- z^2 + c step with full-precision escape test.
module julia_step import julia_pkg::*; #(
   parameter int W    = W_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  logic signed [W-1:0] zr,
   input  logic signed [W-1:0] zi,
   input  logic signed [W-1:0] cr,
   input  logic signed [W-1:0] ci,
   output logic signed [W-1:0] next_zr,
   output logic signed [W-1:0] next_zi,
   output logic                escape
);
   localparam logic signed [2*W:0] THRESH = (2*W+1)'(4) << (2*FRAC);

   logic signed [2*W-1:0] zr2, zi2, zrzi;
   logic signed [2*W:0]   mag, diff, twice;

   always_comb begin
      zr2   = (2*W)'(zr) * (2*W)'(zr);
      zi2   = (2*W)'(zi) * (2*W)'(zi);
      zrzi  = (2*W)'(zr) * (2*W)'(zi);
      // One extra bit keeps the magnitude and difference exact before the compare/shift.
      mag   = (2*W+1)'(zr2) + (2*W+1)'(zi2);
      diff  = (2*W+1)'(zr2) - (2*W+1)'(zi2);
      twice = (2*W+1)'(zrzi) <<< 1;
      escape  = mag > THRESH;
      next_zr = W'(diff >>> FRAC) + cr;
      next_zi = W'(twice >>> FRAC) + ci;
   end
endmodule

// File: rtl/julia_iter.sv
// Per-pixel escape-time engine: one iteration per clock, result held until accepted.
module julia_iter import julia_pkg::*; #(
   parameter int W        = W_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int MAX_ITER = 31,
   parameter int TAG_W    = 17
) (
   input logic     clk,
   input logic     rst,
   julia_if.slave  bus
);
   localparam logic [7:0] LAST_N = 8'(MAX_ITER - 1);

   state_t              state, state_next;
   logic [7:0]          n;
   logic [7:0]          count_q;
   logic [TAG_W-1:0]    tag_q;
   logic signed [W-1:0] zr, zi, cr, ci;
   logic signed [W-1:0] next_zr, next_zi;
   logic                escape, last, accept;

   julia_step #(.W(W), .FRAC(FRAC)) u_step (
      .zr      (zr),
      .zi      (zi),
      .cr      (cr),
      .ci      (ci),
      .next_zr (next_zr),
      .next_zi (next_zi),
      .escape  (escape)
   );

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_count = count_q;
   assign bus.out_tag   = tag_q;
   assign accept        = bus.in_valid && (state == IDLE);
   assign last          = (n == LAST_N);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid)    state_next = ITER;
         ITER:    if (escape || last)  state_next = DONE;
         DONE:    if (bus.out_ready)   state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         n       <= '0;
         count_q <= '0;
         tag_q   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            n     <= '0;
            tag_q <= bus.in_tag;
         end else if (state == ITER) begin
            // Escape takes priority over the iteration limit.
            if (escape)
               count_q <= n;
            else if (last)
               count_q <= COUNT_INSIDE;
            else
               n <= n + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         zr <= bus.in_zr;
         zi <= bus.in_zi;
         cr <= bus.in_cr;
         ci <= bus.in_ci;
      end else if (state == ITER) begin
         zr <= next_zr;
         zi <= next_zi;
      end
   end
endmodule

// File: tb/tb_julia_iter.sv
// Directed and randomized checks of julia_iter against a real-valued escape-time model.
module tb_julia_iter;
   localparam int W        = 16;
   localparam int FRAC     = 12;
   localparam int MAX_ITER = 31;
   localparam int TAG_W    = 17;
   localparam real SCALE   = 4096.0;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   julia_if #(.W(W), .TAG_W(TAG_W)) bus ();

   julia_iter #(.W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Escape-time rule evaluated on real numbers; floor() models the fixed-point truncation.
   function automatic int ref_count(input int zr0, input int zi0, input int cr0, input int ci0);
      real x, y, cx, cy, nx, ny;
      x  = $itor(zr0) / SCALE;
      y  = $itor(zi0) / SCALE;
      cx = $itor(cr0) / SCALE;
      cy = $itor(ci0) / SCALE;
      for (int k = 0; k < MAX_ITER; k++) begin
         if (x * x + y * y > 4.0) return k;
         nx = $floor((x * x - y * y) * SCALE) / SCALE + cx;
         ny = $floor(2.0 * x * y * SCALE) / SCALE + cy;
         x  = nx;
         y  = ny;
      end
      return 255;
   endfunction

   task automatic offer(input int zr0, input int zi0, input int cr0, input int ci0,
                        input logic [TAG_W-1:0] tg);
      bus.in_zr    = W'(zr0);
      bus.in_zi    = W'(zi0);
      bus.in_cr    = W'(cr0);
      bus.in_ci    = W'(ci0);
      bus.in_tag   = tg;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic run_job(input string name, input int zr0, input int zi0, input int cr0,
                          input int ci0, input logic [TAG_W-1:0] tg, input int hold);
      int exp_cnt, exp_lat, cyc;
      exp_cnt = ref_count(zr0, zi0, cr0, ci0);
      exp_lat = (exp_cnt == 255) ? MAX_ITER : exp_cnt + 1;
      check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      offer(zr0, zi0, cr0, ci0, tg);
      cyc = 0;
      while (!bus.out_valid && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({name, "_count"}, 32'(bus.out_count), 32'(exp_cnt));
      check({name, "_tag"}, 32'(bus.out_tag), 32'(tg));
      repeat (hold) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({name, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
   endtask

   initial begin
      int held_cnt, held_tag, seen;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_zr = '0; bus.in_zi = '0; bus.in_cr = '0; bus.in_ci = '0; bus.in_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready",  32'(bus.in_ready),  32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_count",     32'(bus.out_count), 32'd0);
      check("reset_tag",       32'(bus.out_tag),   32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_job("esc0",    12288, 0, 0,     0, 17'h00011, 0);
      run_job("c_one",   0,     0, 4096,  0, 17'h00022, 0);
      run_job("c_m2",    0,     0, -8192, 0, 17'h00033, 0);
      run_job("origin",  0,     0, 0,     0, 17'h1ABCD, 0);
      check("c_one_model",  32'(ref_count(0, 0, 4096, 0)),  32'd3);
      check("c_m2_model",   32'(ref_count(0, 0, -8192, 0)), 32'd255);

      // Result held against back-pressure while a new job is offered.
      check("hold_in_ready", 32'(bus.in_ready), 32'd1);
      offer(4096, 4096, 0, 0, 17'h0F0F0);
      while (!bus.out_valid) @(posedge clk);
      #1;
      held_cnt = int'(bus.out_count);
      held_tag = int'(bus.out_tag);
      check("hold_first_count", 32'(held_cnt), 32'(ref_count(4096, 4096, 0, 0)));
      bus.in_zr = W'(12288); bus.in_zi = '0; bus.in_tag = 17'h05555;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid",    32'(bus.out_valid), 32'd1);
         check("hold_count",    32'(bus.out_count), 32'(held_cnt));
         check("hold_tag",      32'(bus.out_tag),   32'(held_tag));
         check("hold_no_ready", 32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("hold_release_ready", 32'(bus.in_ready),  32'd1);
      check("hold_release_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("hold_no_accept", 32'(bus.in_ready), 32'd1);

      // Reset during iteration 5 of an inside point.
      offer(0, 0, 0, 0, 17'h12345);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_count",     32'(bus.out_count), 32'd0);
      check("midrst_tag",       32'(bus.out_tag),   32'd0);
      #2;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check("midrst_no_output", 32'(seen), 32'd0);
      run_job("after_rst", 12288, 0, 0, 0, 17'h00777, 1);

      for (int j = 0; j < 25; j++) begin
         int rzr, rzi, rcr, rci;
         rzr = int'($urandom_range(0, 11468)) - 5734;
         rzi = int'($urandom_range(0, 11468)) - 5734;
         rcr = int'($urandom_range(0, 16384)) - 8192;
         rci = int'($urandom_range(0, 16384)) - 8192;
         run_job($sformatf("rand%0d", j), rzr, rzi, rcr, rci,
                 TAG_W'($urandom), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
